// File: rtl/omem_spike_collector_if.sv
// omem_spike_collector_if
// Bundles every handshake and status signal of the output-spike collector.
//   in_*     : result beats from the PPE/router side (ts, address, value)
//   start_*  : start token of an output stream
//   hdr_*    : per-timestep header (timestep, layer id)
//   sp_*     : address/data beats of the stream
//   done_*   : done token closing the stream
//   err_dup, err_range, busy : sticky error flags and activity status
// Modports: master = the collector, slave = its environment (PPE + host).
interface omem_spike_collector_if #(
  parameter int WIDTH_ADDR = 12,
  parameter int WIDTH_OUT  = 13
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_ts;
  logic [WIDTH_ADDR-1:0] in_addr;
  logic [WIDTH_OUT-1:0]  in_data;
  logic                  start_valid;
  logic                  start_ready;
  logic                  hdr_valid;
  logic                  hdr_ready;
  logic [1:0]            hdr_ts;
  logic [1:0]            hdr_layer;
  logic                  sp_valid;
  logic                  sp_ready;
  logic [WIDTH_ADDR-1:0] sp_addr;
  logic [WIDTH_OUT-1:0]  sp_data;
  logic                  done_valid;
  logic                  done_ready;
  logic                  err_dup;
  logic                  err_range;
  logic                  busy;

  modport master (
    input  in_valid, in_ts, in_addr, in_data,
    input  start_ready, hdr_ready, sp_ready, done_ready,
    output in_ready, start_valid, hdr_valid, hdr_ts, hdr_layer,
    output sp_valid, sp_addr, sp_data, done_valid,
    output err_dup, err_range, busy
  );

  modport slave (
    output in_valid, in_ts, in_addr, in_data,
    output start_ready, hdr_ready, sp_ready, done_ready,
    input  in_ready, start_valid, hdr_valid, hdr_ts, hdr_layer,
    input  sp_valid, sp_addr, sp_data, done_valid,
    input  err_dup, err_range, busy
  );
endinterface

// File: rtl/omem_spike_collector.sv
// omem_spike_collector
// Collects (timestep, address, value) result beats into one bank per
// timestep. When every neuron of every bank has been written it streams:
// start token, then per timestep a header followed by N address/data beats
// in address order, then a done token.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous, active-high
//   bus   : omem_spike_collector_if.master (input beats, output stream,
//           sticky error flags, busy)
module omem_spike_collector #(
  parameter int         DEPTH_R    = 21,
  parameter int         NUM_TS     = 2,
  parameter int         WIDTH_ADDR = 12,
  parameter int         WIDTH_OUT  = 13,
  parameter logic [1:0] LAYER_ID   = 2'd1
) (
  input logic                    clk,
  input logic                    reset,
  omem_spike_collector_if.master bus
);
  localparam int N     = DEPTH_R * DEPTH_R;
  localparam int IDX_W = $clog2(N);
  localparam int TS_W  = (NUM_TS > 1) ? $clog2(NUM_TS) : 1;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [2:0] {COLLECT, START, HDR, DATA, DONE} state_t;
  state_t state_reg, state_next;

  logic [WIDTH_OUT-1:0] mem [NUM_TS][N];

  logic [IDX_W-1:0]     rptr_reg;
  logic [TS_W-1:0]      tptr_reg;
  logic [1:0]           hdr_ts_reg;
  logic [1:0]           hdr_layer_reg;
  logic [WIDTH_OUT-1:0] sp_data_reg;
  logic                 err_dup_reg;
  logic                 err_range_reg;

  logic [NUM_TS-1:0] full_vec;
  logic [NUM_TS-1:0] seen_vec;   // written bit of the addressed neuron, per bank
  logic              all_full;

  // Input beat decode
  logic             in_fire, in_ok, wr_en, wr_dup;
  logic [TS_W-1:0]  wr_bank;
  logic [IDX_W-1:0] wr_idx;

  assign in_fire = bus.in_valid && (state_reg == COLLECT);
  assign in_ok   = (int'(bus.in_ts) >= 1) && (int'(bus.in_ts) <= NUM_TS) &&
                   (int'(bus.in_addr) < N);
  // Truncation is safe: both indices are only used when in_ok holds.
  assign wr_bank = TS_W'(bus.in_ts - 2'd1);
  assign wr_idx  = bus.in_addr[IDX_W-1:0];
  assign wr_en   = in_fire && in_ok;
  assign wr_dup  = seen_vec[wr_bank];

  // Output handshakes
  logic start_fire, hdr_fire, sp_fire, done_fire, last_beat, last_ts;
  assign start_fire = (state_reg == START) && bus.start_ready;
  assign hdr_fire   = (state_reg == HDR)   && bus.hdr_ready;
  assign sp_fire    = (state_reg == DATA)  && bus.sp_ready;
  assign done_fire  = (state_reg == DONE)  && bus.done_ready;
  assign last_beat  = (rptr_reg == IDX_W'(N - 1));
  assign last_ts    = (tptr_reg == TS_W'(NUM_TS - 1));

  // Per-bank written bits and fill counters
  genvar gi;
  generate
    for (gi = 0; gi < NUM_TS; gi++) begin : g_bank
      logic [N-1:0]     written_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             hit;

      assign seen_vec[gi] = written_reg[wr_idx];
      assign hit          = wr_en && (wr_bank == TS_W'(gi)) && !written_reg[wr_idx];
      assign full_vec[gi] = (cnt_reg == CNT_W'(N));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          written_reg <= '0;
          cnt_reg     <= '0;
        end else if (done_fire) begin
          written_reg <= '0;
          cnt_reg     <= '0;
        end else if (hit) begin
          written_reg[wr_idx] <= 1'b1;
          cnt_reg             <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  // Registered counters: START follows one edge after the completing write.
  assign all_full = &full_vec;

  // Bank storage; duplicates simply overwrite.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_bank][wr_idx] <= bus.in_data;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= COLLECT;
    else       state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (all_full)     state_next = START;
      START:   if (start_fire)   state_next = HDR;
      HDR:     if (hdr_fire)     state_next = DATA;
      DATA:    if (sp_fire && last_beat) state_next = last_ts ? DONE : HDR;
      DONE:    if (done_fire)    state_next = COLLECT;
      default:                   state_next = COLLECT;
    endcase
  end

  // FSM: outputs (valids depend on state only, never on ready)
  always_comb begin
    bus.in_ready    = 1'b0;
    bus.start_valid = 1'b0;
    bus.hdr_valid   = 1'b0;
    bus.sp_valid    = 1'b0;
    bus.done_valid  = 1'b0;
    bus.busy        = 1'b1;
    case (state_reg)
      COLLECT: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
      end
      START:   bus.start_valid = 1'b1;
      HDR:     bus.hdr_valid   = 1'b1;
      DATA:    bus.sp_valid    = 1'b1;
      DONE:    bus.done_valid  = 1'b1;
      default: ;
    endcase
  end

  // Stream pointers and payload registers. sp_data is prefetched on the
  // transfer that precedes a beat, so a beat can leave every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr_reg      <= '0;
      tptr_reg      <= '0;
      hdr_ts_reg    <= '0;
      hdr_layer_reg <= '0;
      sp_data_reg   <= '0;
    end else if (start_fire) begin
      tptr_reg      <= '0;
      hdr_ts_reg    <= 2'd1;
      hdr_layer_reg <= LAYER_ID;
    end else if (hdr_fire) begin
      rptr_reg    <= '0;
      sp_data_reg <= mem[tptr_reg][IDX_W'(0)];
    end else if (sp_fire) begin
      if (last_beat) begin
        if (!last_ts) begin
          tptr_reg   <= tptr_reg + TS_W'(1);
          hdr_ts_reg <= hdr_ts_reg + 2'd1;
        end
      end else begin
        rptr_reg    <= rptr_reg + IDX_W'(1);
        sp_data_reg <= mem[tptr_reg][rptr_reg + IDX_W'(1)];
      end
    end
  end

  // Sticky error flags survive DONE; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_dup_reg   <= 1'b0;
      err_range_reg <= 1'b0;
    end else begin
      if (wr_en && wr_dup)    err_dup_reg   <= 1'b1;
      if (in_fire && !in_ok)  err_range_reg <= 1'b1;
    end
  end

  assign bus.hdr_ts    = hdr_ts_reg;
  assign bus.hdr_layer = hdr_layer_reg;
  assign bus.sp_addr   = WIDTH_ADDR'(rptr_reg);
  assign bus.sp_data   = sp_data_reg;
  assign bus.err_dup   = err_dup_reg;
  assign bus.err_range = err_range_reg;
endmodule
